// File: rtl/serial_transceiver_pkg.sv
// Shared definitions for the serial transmit path and its flow controller.
package serial_transceiver_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BIT_CYCLES = 4;

  // One-hot transmitter states
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    START = 5'b00010,
    DATA  = 5'b00100,
    STOP  = 5'b01000,
    DONE  = 5'b10000
  } tx_state_t;

endpackage

// File: rtl/serial_transceiver_bit_tick_gen.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 while enabled, pulses tick on
// the last count of each period, and restarts from 0 whenever disabled.
module bit_tick_gen
  import serial_transceiver_pkg::*;
#(
  parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic Clk,
  input  logic Reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  // Period counter, wraps at LAST and is held at 0 when disabled
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (!enable || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/serial_transceiver.sv
// Serial transmitter: double-buffered parallel word, framed as start bit,
// MSB-first data bits and stop bit, each held BIT_CYCLES clocks.
module serial_transceiver
  import serial_transceiver_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  SampleData,
  input  logic                  TxData,
  input  logic                  Active,
  output logic                  Dout,
  output logic                  TxBusy,
  output logic                  TxDone
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] shift;
  logic [IW-1:0]         bit_idx;
  logic                  tx_prev;
  logic                  tick;
  logic                  tick_en;
  logic                  start_cond;

  assign tick_en    = Active && (state inside {START, DATA, STOP});
  assign start_cond = (state == IDLE) && Active && TxData && !tx_prev;

  bit_tick_gen #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_tick (
    .Clk   (Clk),
    .Reset (Reset),
    .enable(tick_en),
    .tick  (tick)
  );

  // Hold register and TxData edge history, updated every cycle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hold    <= '0;
      tx_prev <= 1'b0;
    end else begin
      tx_prev <= TxData;
      if (SampleData) begin
        hold <= DataIn;
      end
    end
  end

  // Frame sequencer; outputs are registered from the state held during the
  // previous cycle, so the start bit appears one edge after the start
  // condition and TxDone pulses on the edge that leaves DONE. An abort
  // bypasses that lag and forces the idle outputs at once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      Dout    <= 1'b1;
      TxBusy  <= 1'b0;
      TxDone  <= 1'b0;
    end else if (!Active && (state != IDLE)) begin
      state   <= IDLE;
      bit_idx <= '0;
      Dout    <= 1'b1;
      TxBusy  <= 1'b0;
      TxDone  <= 1'b0;
    end else begin
      Dout   <= (state == START) ? 1'b0 :
                (state == DATA)  ? shift[DATA_WIDTH-1] : 1'b1;
      TxBusy <= (state inside {START, DATA, STOP});
      TxDone <= (state == DONE);
      case (state)
        IDLE: begin
          if (start_cond) begin
            state   <= START;
            shift   <= SampleData ? DataIn : hold;
            bit_idx <= IW'(DATA_WIDTH - 1);
          end
        end
        START: begin
          if (tick) state <= DATA;
        end
        DATA: begin
          if (tick) begin
            shift <= shift << 1;
            if (bit_idx == '0) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx - IW'(1);
            end
          end
        end
        STOP: begin
          if (tick) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
